// File: rtl/usr_piso_serializer.sv
// usr_piso_serializer: accepts parallel words over valid/ready and shifts them out one bit per clock,
// MSB first for left shifts and LSB first for right shifts, counting completed words.
module usr_piso_serializer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             pause,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy,
   output logic [CNT_W-1:0] frame_count
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic             dir_q;
   logic [CW-1:0]    cnt;
   logic             accept;
   always_comb begin
      busy      = state == SHIFT;
      ser_valid = busy && !pause;
      ser_last  = ser_valid && cnt == '0;
      ser_out   = ser_valid ? (dir_q ? shreg[0] : shreg[WIDTH-1]) : 1'b0;
      in_ready  = !busy || ser_last;
      accept    = in_valid && in_ready;
      state_nxt = accept ? SHIFT : (ser_last ? IDLE : state);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   // a new word loaded on the last bit takes priority over the final shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg       <= '0;
         dir_q       <= 1'b0;
         cnt         <= '0;
         frame_count <= '0;
      end else begin
         if (accept) begin
            shreg <= in_data;
            dir_q <= in_dir;
            cnt   <= CW'(WIDTH - 1);
         end else if (ser_valid && cnt != '0) begin
            shreg <= dir_q ? shreg >> 1 : shreg << 1;
            cnt   <= cnt - CW'(1);
         end
         if (ser_last) frame_count <= frame_count + CNT_W'(1);
      end
   end
endmodule
